// File: rtl/gpout_uart_tx.sv
// gpout_uart_tx: byte queue fed from a core's GPOUT word, drained by an 8N1
// UART transmitter on tx. A registered status/ack word goes back on GPIN so
// firmware can poll occupancy, overflow and strobe acknowledge.
module gpout_uart_tx #(
  parameter int TAM    = 16,
  parameter int CLKDIV = 16,
  parameter int LFIFO  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TAM-1:0] GPOUT,
  output logic [TAM-1:0] GPIN,
  output logic           tx
);

  localparam int DEPTH   = 1 << LFIFO;
  localparam int BW      = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam int ACK_BIT = 15;
  localparam int CLR_BIT = 14;

  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKDIV - 1);
  localparam logic [BW-1:0]    BAUD_ONE  = BW'(1'b1);
  localparam logic [BW-1:0]    BAUD_ZERO = {BW{1'b0}};
  localparam logic [LFIFO:0]   CNT_FULL  = (LFIFO + 1)'(DEPTH);
  localparam logic [LFIFO:0]   CNT_ONE   = (LFIFO + 1)'(1'b1);
  localparam logic [LFIFO:0]   CNT_ZERO  = {(LFIFO + 1){1'b0}};
  localparam logic [LFIFO-1:0] PTR_ONE   = LFIFO'(1'b1);
  localparam logic [LFIFO-1:0] PTR_ZERO  = {LFIFO{1'b0}};
  localparam logic [TAM-1:0]   GPIN_RST  = {{(TAM - 3){1'b0}}, 3'b100};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Registers and their next-state values
  state_t           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             strb_q, strb_d;
  logic             ovf_q, ovf_d;
  logic [LFIFO-1:0] wr_ptr_q, wr_ptr_d;
  logic [LFIFO-1:0] rd_ptr_q, rd_ptr_d;
  logic [LFIFO:0]   cnt_q, cnt_d;
  logic [TAM-1:0]   gpin_q, gpin_d;
  logic [7:0]       mem_q [DEPTH];

  // Combinational helpers
  logic fire_s, push_s, clr_s, pop_s, wr_en_s;
  logic empty_s, full_s, bnd_s;
  logic gpout_unused_s;

  // Only bits 15, 14 and 7:0 of GPOUT carry meaning.
  assign gpout_unused_s = ^GPOUT;

  // Command decode: a change of GPOUT[15] against the last accepted level fires one command.
  always_comb begin
    fire_s = GPOUT[ACK_BIT] ^ strb_q;
    if (fire_s) begin
      strb_d = GPOUT[ACK_BIT];
      push_s = ~GPOUT[CLR_BIT];
      clr_s  = GPOUT[CLR_BIT];
    end else begin
      strb_d = strb_q;
      push_s = 1'b0;
      clr_s  = 1'b0;
    end
  end

  // FIFO level flags and bit-period boundary detect from current state.
  always_comb begin
    empty_s = (cnt_q == CNT_ZERO);
    full_s  = (cnt_q == CNT_FULL);
    bnd_s   = (baud_q == BAUD_LAST);
  end

  // Transmit sequencing: start, 8 data bits LSB first, stop; pops the FIFO head on frame start.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_s   = 1'b0;
    if (bnd_s) begin
      baud_d = BAUD_ZERO;
    end else begin
      baud_d = baud_q + BAUD_ONE;
    end
    case (state_q)
      ST_IDLE: begin
        baud_d = BAUD_ZERO;
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_START;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = 3'd0;
          tx_d    = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      ST_START: begin
        if (bnd_s) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          tx_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (bnd_s) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          tx_d = tx_q;
        end
      end
      ST_STOP: begin
        if (bnd_s) begin
          if (!empty_s) begin
            // Next byte waiting: start bit follows the stop bit with no idle gap.
            pop_s   = 1'b1;
            state_d = ST_START;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = 3'd0;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          tx_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = BAUD_ZERO;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping: a push on a full queue only lands when the same edge pops.
  always_comb begin
    wr_en_s = push_s & (~full_s | pop_s);
    if (clr_s) begin
      ovf_d = 1'b0;
    end else if (push_s & full_s & ~pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Status word built from next-state values so GPIN reflects an edge's effects right after it.
  always_comb begin
    gpin_d              = {TAM{1'b0}};
    gpin_d[0]           = (state_d != ST_IDLE) | (cnt_d != CNT_ZERO);
    gpin_d[1]           = (cnt_d == CNT_FULL);
    gpin_d[2]           = (cnt_d == CNT_ZERO);
    gpin_d[3]           = ovf_d;
    gpin_d[LFIFO+4:4]   = cnt_d;
    gpin_d[ACK_BIT]     = strb_d;
  end

  // Control and output registers; reset drops the line high and discards the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= BAUD_ZERO;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      strb_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      cnt_q    <= CNT_ZERO;
      gpin_q   <= GPIN_RST;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      strb_q   <= strb_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      gpin_q   <= gpin_d;
    end
  end

  // FIFO storage; a slot is always written before it is read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= GPOUT[7:0];
    end
  end

  assign GPIN = gpin_q;
  assign tx   = tx_q;

endmodule

// File: tb/tb_gpout_uart_tx.sv
// Testbench for gpout_uart_tx: frame-level reference model checked every
// cycle, a line receiver, and directed literal checks.
module tb_gpout_uart_tx;

  localparam int TAM    = 16;
  localparam int CLKDIV = 4;
  localparam int LFIFO  = 2;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 10 * CLKDIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] GPOUT;
  logic [15:0] GPIN;
  logic        tx;

  int n_chk  = 0;
  int n_pass = 0;

  gpout_uart_tx #(.TAM(TAM), .CLKDIV(CLKDIV), .LFIFO(LFIFO)) dut (
    .clk  (clk),
    .rst  (rst),
    .GPOUT(GPOUT),
    .GPIN (GPIN),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  // Reference model: queue of bytes, current frame byte and cycle position in frame
  logic [7:0] mq[$];
  logic [7:0] m_sent[$];
  logic       m_strb = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       m_act  = 1'b0;
  int         m_t    = 0;
  logic [7:0] m_byte = 8'h00;

  // Line receiver
  logic [7:0] rx_q[$];
  logic       rx_on = 1'b0;
  int         rx_c  = 0;
  logic [7:0] rx_sh = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_tx();
    int slot;
    if (!m_act) return 1'b1;
    slot = m_t / CLKDIV;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_byte[slot-1];
  endfunction

  function automatic logic [15:0] exp_gpin();
    int n;
    n = mq.size();
    return {m_strb, 8'h00, n[2:0], m_ovf, (n == 0), (n == DEPTH), (m_act || n != 0)};
  endfunction

  // Model update on each active edge (or asynchronously on reset)
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete();
      m_strb = 1'b0;
      m_ovf  = 1'b0;
      m_act  = 1'b0;
      m_t    = 0;
      m_byte = 8'h00;
    end else begin
      if (m_act && m_t < FRAME - 1) begin
        m_t = m_t + 1;
      end else if (mq.size() > 0) begin
        m_byte = mq.pop_front();
        m_sent.push_back(m_byte);
        m_act = 1'b1;
        m_t   = 0;
      end else begin
        m_act = 1'b0;
        m_t   = 0;
      end
      if (GPOUT[15] != m_strb) begin
        m_strb = GPOUT[15];
        if (GPOUT[14]) m_ovf = 1'b0;
        else if (mq.size() < DEPTH) mq.push_back(GPOUT[7:0]);
        else m_ovf = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("cyc_tx", 32'(tx), 32'(exp_tx()));
    chk("cyc_gpin", 32'(GPIN), 32'(exp_gpin()));
  end

  // Receiver: samples mid-bit, collects decoded bytes
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx == 1'b0) begin
        rx_on = 1'b1;
        rx_c  = 0;
      end
    end else begin
      rx_c++;
      if ((rx_c % CLKDIV) == CLKDIV / 2 && rx_c / CLKDIV >= 1 && rx_c / CLKDIV <= 8)
        rx_sh[rx_c/CLKDIV-1] = tx;
      if (rx_c == 9 * CLKDIV + CLKDIV / 2) begin
        rx_q.push_back(rx_sh);
        rx_on = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd(input logic clr, input logic [7:0] b);
    logic [15:0] g;
    g       = GPOUT;
    g[15]   = ~g[15];
    g[14]   = clr;
    g[13:8] = 6'($urandom_range(0, 63));
    g[7:0]  = b;
    GPOUT   = g;
    cyc(2);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((m_act || mq.size() != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    cyc(4);
    chk(nm, 32'(k < 3000), 32'd1);
  endtask

  initial begin
    logic [9:0]  pat;
    logic [19:0] pat2;
    logic [7:0]  e;
    int          bad;

    rst   = 1'b1;
    GPOUT = 16'h0000;
    #2 rst = 1'b0;

    // Reset state
    cyc(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_gpin", 32'(GPIN), 32'h0004);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (tx !== 1'b1 || GPIN !== 16'h0004) bad++;
    end
    chk("quiet_after_reset", 32'(bad), 32'd0);

    // Single byte 0xA5
    rx_q.delete();
    GPOUT = 16'h80A5;
    cyc(1);
    chk("single_push_gpin", 32'(GPIN), 32'h8011);
    chk("single_no_early_start", 32'(tx), 32'd1);
    pat = {1'b1, 8'hA5, 1'b0};
    bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc(1);
      if (i == 0) chk("single_start_latency", 32'(tx), 32'd0);
      if (tx !== pat[i/CLKDIV]) bad++;
    end
    chk("single_frame_bits", 32'(bad), 32'd0);
    cyc(1);
    chk("single_done_gpin", 32'(GPIN), 32'h8004);
    chk("single_rx_n", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("single_rx_byte", 32'(rx_q[0]), 32'hA5);

    // Overflow and clear
    wait_idle("idle_ovf");
    rx_q.delete();
    cmd(1'b0, 8'h11);
    cmd(1'b0, 8'h22);
    cmd(1'b0, 8'h33);
    cmd(1'b0, 8'h44);
    cmd(1'b0, 8'h55);
    cmd(1'b0, 8'h66);
    chk("ovf_gpin", 32'(GPIN & 16'h7FFF), 32'h004B);
    chk("ovf_ack", 32'(GPIN[15]), 32'(GPOUT[15]));
    cmd(1'b1, 8'h00);
    chk("clr_gpin", 32'(GPIN & 16'h7FFF), 32'h0043);
    wait_idle("drain_ovf");
    chk("ovf_rx_n", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      e = 8'((i + 1) * 17);
      chk("ovf_rx_byte", 32'(rx_q[i]), 32'(e));
    end

    // Back-to-back frames
    wait_idle("idle_b2b");
    rx_q.delete();
    GPOUT = {~GPOUT[15], 1'b0, 6'h00, 8'h00};
    cyc(2);
    pat2 = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    bad = 0;
    if (tx !== pat2[0]) bad++;
    GPOUT = {~GPOUT[15], 1'b0, 6'h00, 8'hFF};
    for (int i = 1; i < 2 * FRAME; i++) begin
      cyc(1);
      if (tx !== pat2[i/CLKDIV]) bad++;
    end
    chk("b2b_line", 32'(bad), 32'd0);
    cyc(1);
    chk("b2b_end_tx", 32'(tx), 32'd1);
    chk("b2b_end_gpin", 32'(GPIN & 16'h7FFF), 32'h0004);
    chk("b2b_rx_n", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() > 1) begin
      chk("b2b_rx0", 32'(rx_q[0]), 32'h00);
      chk("b2b_rx1", 32'(rx_q[1]), 32'hFF);
    end

    // Simultaneous push and pop while full
    wait_idle("idle_pp");
    rx_q.delete();
    for (int i = 0; i < 5; i++) cmd(1'b0, 8'(8'hA1 + i));
    cyc(31);
    chk("pp_full_before", 32'(GPIN[1]), 32'd1);
    GPOUT = {~GPOUT[15], 1'b0, 6'h00, 8'h77};
    cyc(1);
    chk("pp_cnt", 32'(GPIN[6:4]), 32'd4);
    chk("pp_ovf", 32'(GPIN[3]), 32'd0);
    chk("pp_ack", 32'(GPIN[15]), 32'(GPOUT[15]));
    wait_idle("drain_pp");
    chk("pp_rx_n", 32'(rx_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      e = (i < 5) ? 8'(8'hA1 + i) : 8'h77;
      chk("pp_rx_byte", 32'(rx_q[i]), 32'(e));
    end

    // Reset mid-frame during data bit 3 of 0xA5, two bytes queued
    wait_idle("idle_mid");
    rx_q.delete();
    cmd(1'b0, 8'hA5);
    cmd(1'b0, 8'hB1);
    cmd(1'b0, 8'hB2);
    cyc(13);
    chk("mid_pre_rst_tx", 32'(tx), 32'd0);
    chk("mid_pre_rst_cnt", 32'(GPIN[6:4]), 32'd2);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_async_tx", 32'(tx), 32'd1);
    chk("mid_rst_gpin", 32'(GPIN), 32'h0004);
    GPOUT = 16'h0000;
    cyc(2);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (tx !== 1'b1 || GPIN !== 16'h0004) bad++;
    end
    chk("mid_post_quiet", 32'(bad), 32'd0);
    chk("mid_post_rx_n", 32'(rx_q.size()), 32'd0);

    // Randomized command stream
    rx_q.delete();
    m_sent.delete();
    for (int n = 0; n < 250; n++) begin
      cmd($urandom_range(0, 7) == 0, 8'($urandom));
      cyc($urandom_range(0, 40));
    end
    wait_idle("drain_rand");
    chk("rand_rx_n", 32'(rx_q.size()), 32'(m_sent.size()));
    for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++) begin
      chk("rand_rx_byte", 32'(rx_q[i]), 32'(m_sent[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gpout_uart_tx.md
# gpout_uart_tx

Serial transmit peripheral hung off the dual-core top's general-purpose output port. The owning core writes a byte plus a toggle strobe into GPOUT. The block queues the byte in a small FIFO and shifts it out as 8N1 UART on `tx`. Status, including a strobe acknowledge, comes back on a word meant to be wired to GPIN so firmware can poll it.

## Interface
- `TAM`, 16, data word width; must match the core top.
- `CLKDIV`, 16, clock cycles per UART bit; minimum 2.
- `LFIFO`, 2, log2 of FIFO depth (depth 4 by default).

- `clk`, in, 1, system clock; all state changes on its rising edge.
- `rst`, in, 1, reset, asynchronous, active-low.
- `GPOUT`, in, TAM, command word from the core top:
  - [15] push strobe, toggle-based.
  - [14] clear-overflow qualifier.
  - [7:0] payload.
  - Other bits are ignored.
- `GPIN`, out, TAM, status word, registered:
  - [0] busy.
  - [1] full.
  - [2] empty.
  - [3] overflow, sticky.
  - [LFIFO+4:4] occupancy.
  - [15] ack, the last accepted strobe level.
  - All other bits 0.
- `tx`, out, 1, UART line; idles high.

## Operation
- **Strobe detect.** Register `strb_q` holds the last sampled GPOUT[15]. A command fires on any rising edge where GPOUT[15] != `strb_q`; `strb_q` updates on that same edge. The ack bit GPIN[15] equals `strb_q`, so firmware waits for ack == the strobe level it wrote.
- **Command decode** (on fire):
  - GPOUT[14]=1: clear overflow; nothing is pushed.
  - GPOUT[14]=0: push GPOUT[7:0].
- **FIFO.** Depth 2^LFIFO, circular read/write pointers that wrap modulo depth, occupancy counter of width LFIFO+1.
  - Push while not full: accepted.
  - Push while full with no pop on the same edge: byte dropped, overflow set to 1.
  - Push and pop on the same edge (including when full): both take effect; occupancy unchanged; no overflow.
  - Push while empty: no bypass. The byte is stored and popped on a later edge.
- **Transmit FSM**, states IDLE, START, DATA, STOP:
  - IDLE → START when FIFO not empty. That edge pops the head into the shift register, clears the bit counter and the baud counter, and drives `tx` to 0.
  - START: `tx`=0 for CLKDIV cycles → DATA.
  - DATA: 8 bits, LSB first, each held CLKDIV cycles; the shift register shifts right at each bit boundary → STOP after bit 7.
  - STOP: `tx`=1 for CLKDIV cycles. At its end, if FIFO not empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
  - The baud counter is ceil(log2(CLKDIV)) bits, counts 0..CLKDIV-1, and wraps at each bit boundary.
- **Status bits:**
  - busy = (state != IDLE) | !empty.
  - full = occupancy == depth.
  - empty = occupancy == 0.
- `tx` is driven from a register, so the line is glitch-free.

## Timing
- **Reset (asserted, async):**
  - `tx`=1, state IDLE, FIFO pointers and occupancy 0, overflow 0, `strb_q`=0.
  - GPIN = 0x0004 (only empty set), for default TAM=16 and LFIFO=2.
- **Reset mid-frame:** `tx` returns high immediately and asynchronously. All queued bytes are discarded. No partial frame resumes after release.
- **Push latency:** when the toggle is applied before edge E, the occupancy and ack in GPIN reflect the push after edge E.
- **Start latency:** from an idle, empty block, `tx` falls after edge E+1, i.e. 2 edges after the toggle is presented.
- **Frame length:** exactly 10·CLKDIV cycles: start, 8 data, stop.
- **Back-to-back:** consecutive frames are contiguous; the next start bit begins on the cycle after the last stop-bit cycle.
- **Minimum command rate:** one command per 2 cycles. Firmware must present each toggle for at least 1 edge.

## Test plan
All scenarios use CLKDIV=4, LFIFO=2.
- **Reset:** hold rst=0 → `tx`=1, GPIN=0x0004. Release, GPOUT held 0x0000 for 20 cycles → no activity.
- **Single byte:** GPOUT 0x0000→0x80A5.
  - After the next edge: GPIN=0x8011 (ack, count 1, busy).
  - `tx` then gives start low 4 cycles, bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles.
  - 40 cycles after `tx` falls: GPIN=0x8004.
- **Overflow and clear:** toggle in 0x11,0x22,0x33,0x44,0x55,0x66 every 2 cycles.
  - 0x11 starts transmitting; 0x22–0x55 fill the FIFO; 0x66 is dropped.
  - GPIN shows full=1, overflow=1, count=4.
  - A toggle with bit14=1 clears overflow without changing count.
  - The line then carries 0x11,0x22,0x33,0x44,0x55 and never 0x66.
- **Back-to-back:** queue 0x00,0xFF → two contiguous 40-cycle frames.
  - No extra high cycle between the first stop bit and the second start bit.
  - Total 80 cycles from the first falling edge to the end of the second stop bit.
- **Simultaneous push/pop at full:** FIFO full, toggle pushing 0x77 applied so it lands on the edge where the FSM pops at the end of a stop bit.
  - Count stays 4, overflow stays 0.
  - 0x77 is transmitted last.
- **Reset mid-frame:** assert rst=0 during data bit 3 of 0xA5 with 2 bytes queued → `tx`=1 in the same cycle, GPIN=0x0004 after release, no further frames.
